// File: rtl/cla_acc_pkg.sv
// cla_acc_pkg: shared width constant and state encoding for the CLA accumulator
package cla_acc_pkg;
  localparam int WIDTH = 44;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/cla_44bit.sv
// cla_44bit: 44-bit carry-lookahead adder, 4-bit lookahead groups, carry-in tied to 0
module cla_44bit
  import cla_acc_pkg::*;
(
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic [WIDTH:0]   o_result
);
  logic [WIDTH-1:0] g, p;
  logic [WIDTH:0] c;
  assign g = i_add1 & i_add2;
  assign p = i_add1 ^ i_add2;
  assign c[0] = 1'b0;
  for (genvar k = 0; k < WIDTH / 4; k++) begin : grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | p[B] & c[B];
    assign c[B+2] = g[B+1] | p[B+1] & g[B] | &p[B+1:B] & c[B];
    assign c[B+3] = g[B+2] | p[B+2] & g[B+1] | &p[B+2:B+1] & g[B] | &p[B+2:B] & c[B];
    assign c[B+4] = g[B+3] | p[B+3] & g[B+2] | &p[B+3:B+2] & g[B+1] | &p[B+3:B+1] & g[B]
                  | &p[B+3:B] & c[B];
  end
  assign o_result = {c[WIDTH], p ^ c[WIDTH-1:0]};
endmodule

// File: rtl/cla_accumulator_44bit.sv
// cla_accumulator_44bit: burst accumulator feeding the CLA result back as its next operand
module cla_accumulator_44bit #(
  parameter int WIDTH = 44,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf,
  input  logic             i_out_ready,
  output logic             o_busy
);
  import cla_acc_pkg::*;
  state_t state, next;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic ovf, fire;
  logic [WIDTH:0] sum;
  cla_44bit adder (.i_add1(acc), .i_add2(i_data), .o_result(sum));
  assign fire = state == ACCUM && i_valid;
  always_comb begin
    next = state;
    next = state == IDLE  ? (i_start ? (i_len == '0 ? DONE : ACCUM) : IDLE) :
           state == ACCUM ? (fire && cnt == CNT_W'(1) ? DONE : ACCUM) :
           state == DONE  ? (i_out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && i_start) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= i_len;
      end else if (fire) begin
        acc <= sum[WIDTH-1:0];
        ovf <= ovf | sum[WIDTH];
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign o_ready = state == ACCUM;
  assign o_valid = state == DONE;
  assign o_busy  = state != IDLE;
  assign o_sum   = acc;
  assign o_ovf   = ovf;
endmodule

// File: tb/tb_cla_accumulator_44bit.sv
// tb_cla_accumulator_44bit: directed bursts with a queue scoreboard checked on each result handshake
module tb_cla_accumulator_44bit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0, out_ready = 1'b0;
  logic [7:0] len = '0;
  logic [43:0] data = '0;
  logic ready, res_valid, ovf, busy;
  logic [43:0] sum;
  int compared = 0, mismatched = 0;
  logic [44:0] sb[$];
  always #5 clk = ~clk;
  cla_accumulator_44bit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_valid(valid),
    .i_data(data), .o_ready(ready), .o_valid(res_valid), .o_sum(sum), .o_ovf(ovf),
    .i_out_ready(out_ready), .o_busy(busy)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (res_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got sum 0x%0h ovf %0b expected none", sum, ovf);
      end else begin
        logic [44:0] e;
        e = sb.pop_front();
        check("result_sum", 64'(sum), 64'(e[43:0]));
        check("result_ovf", 64'(ovf), 64'(e[44]));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    len = n;
    tick();
    start = 1'b0;
  endtask
  task automatic beat(input logic [43:0] d);
    valid = 1'b1;
    data = d;
    tick();
    valid = 1'b0;
  endtask
  task automatic handshake();
    for (int i = 0; i < 20 && res_valid !== 1'b1; i++) tick();
    if (res_valid !== 1'b1) check("result_timeout", 64'(res_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_sum", 64'(sum), 0);
    check("rst_valid", 64'(res_valid), 0);
    check("rst_ready", 64'(ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_ovf", 64'(ovf), 0);
    rst_n = 1'b1;
    tick();
    do_start(3);
    check("basic_ready", 64'(ready), 1);
    beat(44'd1);
    beat(44'd2);
    check("basic_not_done", 64'(res_valid), 0);
    beat(44'd3);
    check("basic_valid", 64'(res_valid), 1);
    sb.push_back({1'b0, 44'd6});
    handshake();
    check("basic_idle_valid", 64'(res_valid), 0);
    check("basic_idle_busy", 64'(busy), 0);
    do_start(2);
    beat(44'hFFF_FFFF_FFFF);
    beat(44'd1);
    sb.push_back({1'b1, 44'd0});
    handshake();
    do_start(1);
    beat(44'd7);
    sb.push_back({1'b0, 44'd7});
    handshake();
    do_start(0);
    check("zero_valid", 64'(res_valid), 1);
    check("zero_ready", 64'(ready), 0);
    check("zero_sum", 64'(sum), 0);
    sb.push_back({1'b0, 44'd0});
    handshake();
    do_start(4);
    beat(44'd10);
    tick();
    beat(44'd20);
    tick();
    tick();
    beat(44'd30);
    tick();
    check("gap_not_done", 64'(res_valid), 0);
    beat(44'd40);
    valid = 1'b1;
    data = 44'd999;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(res_valid), 1);
      check("bp_ready", 64'(ready), 0);
      check("bp_sum", 64'(sum), 100);
      tick();
    end
    valid = 1'b0;
    sb.push_back({1'b0, 44'd100});
    handshake();
    check("bp_idle_busy", 64'(busy), 0);
    check("bp_idle_valid", 64'(res_valid), 0);
    do_start(4);
    beat(44'd1);
    beat(44'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_sum", 64'(sum), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_valid", 64'(res_valid), 0);
    do_start(1);
    beat(44'd5);
    sb.push_back({1'b0, 44'd5});
    handshake();
    do_start(2);
    start = 1'b1;
    len = 8'd9;
    beat(44'd11);
    start = 1'b0;
    check("spur_accum_busy", 64'(res_valid), 0);
    beat(44'd22);
    check("spur_done_valid", 64'(res_valid), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("spur_done_hold", 64'(res_valid), 1);
    check("spur_done_sum", 64'(sum), 33);
    sb.push_back({1'b0, 44'd33});
    handshake();
    tick();
    check("sb_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cla_accumulator_44bit.md
# cla_accumulator_44bit

Sequential accumulator that sits directly downstream of the 44-bit carry-lookahead adder and feeds the adder's own result back as its next operand. It accepts a burst of `i_len` operands over a valid/ready stream and sums them into a 44-bit register. It then presents the sum with a sticky overflow flag on a valid/ready output. Throughput is one operand per clock.

## Interface
- `WIDTH`, default 44: operand and sum width.
- `CNT_W`, default 8: width of the burst-length counter.

- `i_clk`, in, 1: clock. All logic is rising-edge.
- `i_rst_n`, in, 1: reset. Synchronous, active-low.
- `i_start`, in, 1: burst start pulse. Sampled only in IDLE.
- `i_len`, in, CNT_W: number of operands in the burst. Sampled with `i_start`.
- `i_valid`, in, 1: operand valid.
- `i_data`, in, WIDTH: operand.
- `o_ready`, out, 1: operand accepted this cycle when `i_valid & o_ready`.
- `o_valid`, out, 1: result valid.
- `o_sum`, out, WIDTH: accumulated sum, modulo 2^WIDTH.
- `o_ovf`, out, 1: sticky carry-out seen during the burst.
- `i_out_ready`, in, 1: downstream accepts the result.
- `o_busy`, out, 1: high in ACCUM and DONE.

## Operation
- States are IDLE, ACCUM and DONE.
- **Reset** (`i_rst_n`=0 at a clock edge):
  - State goes to IDLE.
  - The accumulator, the counter and `o_ovf` clear to 0.
  - `o_ready`, `o_valid` and `o_busy` are 0.
  - Reset mid-burst discards the partial sum. No result is emitted.
- **IDLE**:
  - `o_ready`=0 and `o_valid`=0.
  - `i_start`=1 with `i_len`≥1: clear the accumulator and `o_ovf`, load counter with `i_len`, go to ACCUM.
  - `i_start`=1 with `i_len`=0: clear the accumulator and `o_ovf`, go to DONE. The burst reports sum 0.
- **ACCUM**:
  - `o_ready`=1.
  - On each cycle with `i_valid`=1:
    - The adder computes accumulator + `i_data`.
    - The accumulator takes result[WIDTH-1:0].
    - `o_ovf` takes `o_ovf` | result[WIDTH].
    - The counter decrements.
  - The beat that is accepted while the counter is 1 moves the state to DONE.
  - `i_valid`=0: no change.
  - `i_start` is ignored.
- **DONE**:
  - `o_valid`=1. `o_sum` and `o_ovf` are held stable.
  - `o_ready`=0. Data on `i_data` is ignored.
  - `i_out_ready`=1: go to IDLE.
  - `i_start` is ignored.
- **Arithmetic**: unsigned, with carry-in fixed to 0. Wrap-around is modulo 2^44. Any carry-out in the burst sets `o_ovf`, and it stays set until the next start or reset.
- `o_sum` equals the accumulator register in every state. It reads 0 after reset.

## Timing
- `i_start` at cycle t puts the block in ACCUM with `o_ready`=1 at t+1.
- Last operand accepted at cycle k: `o_valid`=1 at k+1, with the final `o_sum`.
- Result handshake at cycle d: IDLE at d+1, `o_valid`=0 at d+1.
- Minimum spacing between bursts: the earliest next `i_start` is at d+1.
- The adder path is combinational from the accumulator and `i_data` to the accumulator D input. It is a single-cycle path, with no internal pipelining.
- Backpressure on the output: the block stays in DONE indefinitely. Outputs do not change until the handshake.

## Structure
- Package `cla_acc_pkg` holds:
  - the `WIDTH`=44 constant;
  - the state enum (IDLE, ACCUM, DONE), 2-bit encoding.
- One sub-module: an instance of the existing `cla_44bit` adder.
  - `i_add1` connects to the accumulator.
  - `i_add2` connects to `i_data`.
  - `o_result[44]` is the carry-out used for `o_ovf`.
- All registers (state, accumulator, counter, ovf) live in one clocked process with synchronous active-low reset.

## Test plan
- **Basic burst:** `i_len`=3, operands 1, 2, 3 on consecutive cycles.
  - Required: `o_valid` the cycle after the 3rd beat, `o_sum`=6, `o_ovf`=0.
- **Overflow:** `i_len`=2, operands 0xFFF_FFFF_FFFF and 0x1.
  - Required: `o_sum`=0, `o_ovf`=1.
  - A following burst `i_len`=1, operand 7, gives `o_sum`=7, `o_ovf`=0.
- **Zero-length burst:** `i_start` with `i_len`=0.
  - Required: `o_valid`=1 the next cycle, `o_sum`=0, `o_ovf`=0, and no operand accepted.
- **Stream gaps and output backpressure:** `i_len`=4, operands 10, 20, 30, 40 with `i_valid` idle cycles between them, and `i_out_ready` held low for 5 cycles in DONE.
  - Required: `o_sum`=100, held stable.
  - Required: `o_ready`=0 throughout DONE.
  - Required: IDLE the cycle after `i_out_ready`=1.
- **Reset mid-burst:** `i_len`=4, reset asserted after 2 beats.
  - Required: the next cycle shows `o_sum`=0, `o_busy`=0, `o_valid`=0.
  - A new burst `i_len`=1, operand 5, gives `o_sum`=5.
- **Spurious start:** `i_start` with `i_len`=9 pulsed during ACCUM and during DONE of an `i_len`=2 burst.
  - Required: it is ignored, and the burst completes after 2 beats.
